// File: rtl/pwm_pkg.sv
// Shared constants and types for the RGB PWM driver / capture pair.
// Offsets and the colour-word type describe the default packing {R,G,B}.
package pwm_pkg;

   localparam int unsigned DEF_CNT_W  = 8;
   localparam int unsigned DEF_PERIOD = 1 << DEF_CNT_W;

   localparam int unsigned R_LSB = 2 * DEF_CNT_W;
   localparam int unsigned G_LSB = DEF_CNT_W;
   localparam int unsigned B_LSB = 0;

   typedef logic [3*DEF_CNT_W-1:0] color_t;

endpackage

// File: rtl/pwm_rgb_capture_if.sv
// PWM lines in, reconstructed colour and raw measurement out.
// The slave side is the capture block; the master side drives the lines and watches results.
interface pwm_rgb_capture_if #(
   parameter int unsigned CNT_W = pwm_pkg::DEF_CNT_W
);

   logic               pwm_R;
   logic               pwm_G;
   logic               pwm_B;
   logic [3*CNT_W-1:0] color;
   logic               color_valid;
   logic               color_update;
   logic [3*CNT_W-1:0] meas;
   logic               meas_strobe;
   logic [2:0]         sat;

   modport master (
      output pwm_R, pwm_G, pwm_B,
      input  color, color_valid, color_update, meas, meas_strobe, sat
   );

   modport slave (
      input  pwm_R, pwm_G, pwm_B,
      output color, color_valid, color_update, meas, meas_strobe, sat
   );

endinterface

// File: rtl/pwm_duty_meter.sv
// One channel: input synchroniser, high-time counter over a window, saturating result.
// The window boundary (win_last) comes from the parent so all channels stay aligned.
module pwm_duty_meter
   import pwm_pkg::*;
#(
   parameter int unsigned CNT_W       = DEF_CNT_W,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pwm,
   input  logic             win_last,
   output logic [CNT_W-1:0] meas,
   output logic             sat
);

   localparam logic [CNT_W:0] FULL = {1'b1, {CNT_W{1'b0}}};

   logic           s;
   logic [CNT_W:0] hi;
   logic [CNT_W:0] tot;
   logic           full;

   generate
      if (SYNC_STAGES == 0) begin : g_bypass
         assign s = pwm;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               sync_q <= '0;
            end else begin
               sync_q[0] <= pwm;
               for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                  sync_q[i] <= sync_q[i-1];
               end
            end
         end

         assign s = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   // The last sample of the window is folded in here rather than into hi,
   // so hi can be cleared on the same edge the result is captured.
   assign tot  = hi + {{CNT_W{1'b0}}, s};
   assign full = (tot == FULL);

   always_ff @(posedge clk) begin
      if (rst) begin
         hi   <= '0;
         meas <= '0;
         sat  <= 1'b0;
      end else if (win_last) begin
         hi   <= '0;
         meas <= full ? '1 : tot[CNT_W-1:0];
         sat  <= full;
      end else begin
         hi   <= tot;
      end
   end

endmodule

// File: rtl/pwm_rgb_capture.sv
// Reconstructs the {R,G,B} duty word from three PWM lines over free-running windows
// and publishes it once it has repeated for STABLE_N consecutive windows.
module pwm_rgb_capture
   import pwm_pkg::*;
#(
   parameter int unsigned CNT_W       = DEF_CNT_W,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned STABLE_N    = 2
) (
   input  logic              clk,
   input  logic              rst,
   pwm_rgb_capture_if.slave  bus
);

   localparam logic [3:0] MATCH_MAX = 4'(STABLE_N);

   logic [CNT_W-1:0]   win;
   logic               win_last;
   logic [CNT_W-1:0]   meas_r;
   logic [CNT_W-1:0]   meas_g;
   logic [CNT_W-1:0]   meas_b;
   logic               sat_r;
   logic               sat_g;
   logic               sat_b;
   logic [3*CNT_W-1:0] meas_now;
   logic [3*CNT_W-1:0] prev_meas;
   logic [3*CNT_W-1:0] color_q;
   logic [3:0]         match;
   logic [3:0]         match_nxt;
   logic               publish;
   logic               meas_strobe_q;
   logic               color_update_q;
   logic               color_valid_q;

   assign win_last = &win;

   pwm_duty_meter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_meter_r (
      .clk(clk), .rst(rst), .pwm(bus.pwm_R), .win_last(win_last), .meas(meas_r), .sat(sat_r)
   );
   pwm_duty_meter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_meter_g (
      .clk(clk), .rst(rst), .pwm(bus.pwm_G), .win_last(win_last), .meas(meas_g), .sat(sat_g)
   );
   pwm_duty_meter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_meter_b (
      .clk(clk), .rst(rst), .pwm(bus.pwm_B), .win_last(win_last), .meas(meas_b), .sat(sat_b)
   );

   assign meas_now = {meas_r, meas_g, meas_b};

   // Filter runs in the strobe cycle, when meas_now already holds the new window.
   always_comb begin
      match_nxt = 4'd1;
      if (meas_now == prev_meas) begin
         match_nxt = (match >= MATCH_MAX) ? MATCH_MAX : match + 4'd1;
      end
      publish = meas_strobe_q && (match_nxt == MATCH_MAX) && (meas_now != color_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         win            <= '0;
         meas_strobe_q  <= 1'b0;
         color_update_q <= 1'b0;
         color_valid_q  <= 1'b0;
         color_q        <= '0;
         prev_meas      <= '0;
         match          <= '0;
      end else begin
         win            <= win + 1'b1;
         meas_strobe_q  <= win_last;
         color_update_q <= publish;
         if (meas_strobe_q) begin
            prev_meas <= meas_now;
            match     <= match_nxt;
         end
         if (publish) begin
            color_q       <= meas_now;
            color_valid_q <= 1'b1;
         end
      end
   end

   assign bus.meas         = meas_now;
   assign bus.sat          = {sat_r, sat_g, sat_b};
   assign bus.meas_strobe  = meas_strobe_q;
   assign bus.color        = color_q;
   assign bus.color_valid  = color_valid_q;
   assign bus.color_update = color_update_q;

endmodule
